// File: rtl/sum_ghi_seq.sv
// -----------------------------------------------------------------------------
// sum_ghi_seq
//   Sequencer / accumulator controller for the 121-input GHI adder tree.
//   Paces tile beats into the tree, gates the tree enable, accumulates the
//   per-beat tree sums over a configured number of passes and returns the
//   final sum to the normalisation stage over a valid/ready handshake.
//
// Optional feature (macro SUM_GHI_SAT_EN):
//   defined   - every accumulate saturates at 2^ACC_W-1; a sticky sat_flag
//               output reports that some add in the current job saturated.
//   undefined - modular add, no sat_flag port.
//
// Ports:
//   clk, rst_n    clock (rising edge), asynchronous active-low reset
//   start         one-cycle job start pulse (honoured only in IDLE)
//   abort         synchronous job cancel, wins over everything but reset
//   cfg_passes    beats per job, 0 is treated as 1
//   beat_valid    upstream presents a beat to the tree this cycle
//   beat_ready    controller accepts the beat this cycle
//   tree_en       tree enable, high only in the cycle a beat is accepted
//   tree_hold     tree reg_sum feedback = low TREE_W bits of the accumulator
//   tree_sum      tree out_sum (combinational from the products)
//   res_valid     final sum available
//   res_ready     consumer accepts the result
//   res_sum       final accumulated sum, stable while res_valid
//   busy          job in progress (ACCUM or DONE)
//   pass_idx      beats accepted so far in the current job
//   sat_flag      (SUM_GHI_SAT_EN only) sticky saturation indicator
// -----------------------------------------------------------------------------
module sum_ghi_seq #(
   parameter int TREE_W = 35,
   parameter int ACC_W  = 40,
   parameter int PASS_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [PASS_W-1:0] cfg_passes,
   input  logic              beat_valid,
   output logic              beat_ready,
   output logic              tree_en,
   output logic [TREE_W-1:0] tree_hold,
   input  logic [TREE_W-1:0] tree_sum,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [ACC_W-1:0]  res_sum,
   output logic              busy,
   output logic [PASS_W-1:0] pass_idx
`ifdef SUM_GHI_SAT_EN
   ,
   output logic              sat_flag
`endif
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ACCUM = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   localparam logic [PASS_W-1:0] ONE_PASS = PASS_W'(1);

   logic [1:0]        state_q,     state_d;
   logic [ACC_W-1:0]  acc_q,       acc_d;
   logic [PASS_W-1:0] pass_cnt_q,  pass_cnt_d;
   logic [PASS_W-1:0] passes_q,    passes_d;
   logic              res_valid_q, res_valid_d;
   logic [ACC_W-1:0]  res_sum_q,   res_sum_d;

   logic              accept;
   logic [PASS_W-1:0] pass_cnt_inc;
   logic [ACC_W-1:0]  add_res;

   // Abort kills acceptance in the same cycle so an aborted beat never
   // reaches the accumulator or pulses the tree enable.
   assign beat_ready   = (state_q == S_ACCUM) && !abort;
   assign accept       = beat_valid && beat_ready;
   assign tree_en      = accept;
   assign pass_cnt_inc = pass_cnt_q + ONE_PASS;

   // Feeding back the accumulator keeps the tree output stable while en=0.
   assign tree_hold = acc_q[TREE_W-1:0];

`ifdef SUM_GHI_SAT_EN
   logic             sat_q, sat_d;
   logic [ACC_W:0]   sum_wide;
   logic             add_sat;

   // One guard bit catches the carry out; a carry means clamp to all-ones.
   assign sum_wide = {1'b0, acc_q} + (ACC_W+1)'(tree_sum);
   assign add_sat  = sum_wide[ACC_W];
   assign add_res  = add_sat ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
   assign sat_flag = sat_q;
`else
   assign add_res = acc_q + ACC_W'(tree_sum);
`endif

   // NOTE: every variable gets a default at the top of this block so that
   // no path leaves one unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      pass_cnt_d  = pass_cnt_q;
      passes_d    = passes_q;
      res_valid_d = res_valid_q;
      res_sum_d   = res_sum_q;
`ifdef SUM_GHI_SAT_EN
      sat_d       = sat_q;
`endif
      if (abort) begin
         state_d     = S_IDLE;
         res_valid_d = 1'b0;
         acc_d       = '0;
         pass_cnt_d  = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  passes_d   = (cfg_passes == '0) ? ONE_PASS : cfg_passes;
                  acc_d      = '0;
                  pass_cnt_d = '0;
`ifdef SUM_GHI_SAT_EN
                  sat_d      = 1'b0;
`endif
                  state_d    = S_ACCUM;
               end
            end
            S_ACCUM: begin
               if (accept) begin
                  acc_d      = add_res;
                  pass_cnt_d = pass_cnt_inc;
`ifdef SUM_GHI_SAT_EN
                  sat_d      = sat_q | add_sat;
`endif
                  // Result is taken from the adder directly so it appears
                  // the cycle after the last beat, not two cycles later.
                  if (pass_cnt_inc == passes_q) begin
                     res_sum_d   = add_res;
                     res_valid_d = 1'b1;
                     state_d     = S_DONE;
                  end
               end
            end
            S_DONE: begin
               // start is deliberately not looked at here; a start in the
               // handshake cycle is dropped.
               if (res_ready) begin
                  res_valid_d = 1'b0;
                  state_d     = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // NOTE: state is updated with non-blocking assignments so every flop
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         acc_q       <= '0;
         pass_cnt_q  <= '0;
         passes_q    <= ONE_PASS;
         res_valid_q <= 1'b0;
         res_sum_q   <= '0;
`ifdef SUM_GHI_SAT_EN
         sat_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         pass_cnt_q  <= pass_cnt_d;
         passes_q    <= passes_d;
         res_valid_q <= res_valid_d;
         res_sum_q   <= res_sum_d;
`ifdef SUM_GHI_SAT_EN
         sat_q       <= sat_d;
`endif
      end
   end

   assign res_valid = res_valid_q;
   assign res_sum   = res_sum_q;
   assign busy      = (state_q != S_IDLE);
   assign pass_idx  = pass_cnt_q;

endmodule

// File: tb/tb_sum_ghi_seq.sv
// -----------------------------------------------------------------------------
// tb_sum_ghi_seq
//   Self-checking bench for sum_ghi_seq. Stimulus tasks push the expected
//   final sum of each job (plain arithmetic sum of the beat values, modulo
//   2^ACC_W) into a scoreboard queue; a monitor pops and compares whenever
//   the DUT completes a result handshake.
// -----------------------------------------------------------------------------
module tb_sum_ghi_seq;

   localparam int TREE_W = 35;
   localparam int ACC_W  = 40;
   localparam int PASS_W = 4;
   localparam longint unsigned ACC_MASK  = (64'd1 << ACC_W) - 64'd1;
   localparam longint unsigned TREE_MASK = (64'd1 << TREE_W) - 64'd1;

   logic              clk;
   logic              rst_n;
   logic              start;
   logic              abort;
   logic [PASS_W-1:0] cfg_passes;
   logic              beat_valid;
   logic              beat_ready;
   logic              tree_en;
   logic [TREE_W-1:0] tree_hold;
   logic [TREE_W-1:0] tree_sum;
   logic              res_valid;
   logic              res_ready;
   logic [ACC_W-1:0]  res_sum;
   logic              busy;
   logic [PASS_W-1:0] pass_idx;
`ifdef SUM_GHI_SAT_EN
   logic              sat_flag;
`endif

   sum_ghi_seq #(.TREE_W(TREE_W), .ACC_W(ACC_W), .PASS_W(PASS_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .abort      (abort),
      .cfg_passes (cfg_passes),
      .beat_valid (beat_valid),
      .beat_ready (beat_ready),
      .tree_en    (tree_en),
      .tree_hold  (tree_hold),
      .tree_sum   (tree_sum),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_sum    (res_sum),
      .busy       (busy),
      .pass_idx   (pass_idx)
`ifdef SUM_GHI_SAT_EN
      ,
      .sat_flag   (sat_flag)
`endif
   );

   int n_checks = 0;
   int n_errors = 0;

   longint unsigned sb[$];
   logic [TREE_W-1:0] vals[$];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: a result handshake completes on the next rising edge.
   always @(negedge clk) begin
      if (rst_n && res_valid && res_ready) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL sb_underflow: got result 0x%0h expected none", res_sum);
         end else begin
            check("res_sum", 64'(res_sum), sb.pop_front());
`ifdef SUM_GHI_SAT_EN
            check("sat_flag", 64'(sat_flag), 64'd0);
`endif
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_random(input int n);
      vals.delete();
      for (int i = 0; i < n; i++)
         vals.push_back(TREE_W'({$urandom, $urandom} & TREE_MASK));
   endtask

   // One full job. gap_mode: 0 back-to-back, 1 toggling valid, 2 random gaps.
   // poke drives start and beat_valid while the result waits in DONE.
   task automatic run_job(input logic [PASS_W-1:0] cfg, input int gap_mode,
                          input int stall, input bit poke);
      int n;
      int g;
      longint unsigned exp;
      n   = (cfg == 0) ? 1 : int'(cfg);
      exp = 0;
      step();
      start      = 1'b1;
      cfg_passes = cfg;
      step();
      start      = 1'b0;
      cfg_passes = PASS_W'($urandom);
      check("busy_after_start", 64'(busy), 64'd1);
      check("pass_idx_start", 64'(pass_idx), 64'd0);
      for (int i = 0; i < n; i++) begin
         g = (gap_mode == 1) ? ((i > 0) ? 1 : 0) :
             (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
         for (int k = 0; k < g; k++) begin
            beat_valid = 1'b0;
            tree_sum   = TREE_W'({$urandom, $urandom});
            @(negedge clk);
            check("tree_en_gap", 64'(tree_en), 64'd0);
            check("tree_hold_gap", 64'(tree_hold), exp & TREE_MASK);
            step();
         end
         beat_valid = 1'b1;
         tree_sum   = vals[i];
         @(negedge clk);
         check("tree_en_beat", 64'(tree_en), 64'd1);
         check("pass_idx", 64'(pass_idx), 64'(i));
         check("tree_hold", 64'(tree_hold), exp & TREE_MASK);
         check("res_valid_early", 64'(res_valid), 64'd0);
         exp = (exp + 64'(vals[i])) & ACC_MASK;
         if (i == n - 1) sb.push_back(exp);
         step();
      end
      beat_valid = 1'b0;
      check("res_valid_latency", 64'(res_valid), 64'd1);
      res_ready = 1'b0;
      for (int k = 0; k < stall; k++) begin
         if (poke) begin
            start      = 1'b1;
            beat_valid = 1'b1;
         end
         @(negedge clk);
         check("done_beat_ready", 64'(beat_ready), 64'd0);
         check("done_tree_en", 64'(tree_en), 64'd0);
         check("done_res_valid", 64'(res_valid), 64'd1);
         check("done_res_sum", 64'(res_sum), exp);
         step();
      end
      res_ready = 1'b1;
      step();
      res_ready  = 1'b0;
      start      = 1'b0;
      beat_valid = 1'b0;
      check("busy_after_ack", 64'(busy), 64'd0);
      check("res_valid_after_ack", 64'(res_valid), 64'd0);
   endtask

   initial begin
      rst_n      = 1'b0;
      start      = 1'b0;
      abort      = 1'b0;
      cfg_passes = '0;
      beat_valid = 1'b0;
      tree_sum   = '0;
      res_ready  = 1'b0;

      // Reset state
      #3;
      check("rst_beat_ready", 64'(beat_ready), 64'd0);
      check("rst_tree_en", 64'(tree_en), 64'd0);
      check("rst_res_valid", 64'(res_valid), 64'd0);
      check("rst_res_sum", 64'(res_sum), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_pass_idx", 64'(pass_idx), 64'd0);
      check("rst_tree_hold", 64'(tree_hold), 64'd0);
      #20;
      @(negedge clk);
      rst_n = 1'b1;

      // 3 passes, 100/200/300 back-to-back -> 600
      vals = '{35'd100, 35'd200, 35'd300};
      run_job(4'd3, 0, 1, 1'b0);

      // Reset in the middle of a 4-beat job, then a clean 4-beat job
      step();
      start      = 1'b1;
      cfg_passes = 4'd4;
      step();
      start      = 1'b0;
      beat_valid = 1'b1;
      tree_sum   = 35'd5;
      step();
      tree_sum   = 35'd7;
      step();
      beat_valid = 1'b0;
      check("mid_pass_idx", 64'(pass_idx), 64'd2);
      check("mid_tree_hold", 64'(tree_hold), 64'd12);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_busy", 64'(busy), 64'd0);
      check("arst_beat_ready", 64'(beat_ready), 64'd0);
      check("arst_res_sum", 64'(res_sum), 64'd0);
      check("arst_pass_idx", 64'(pass_idx), 64'd0);
      check("arst_tree_hold", 64'(tree_hold), 64'd0);
      check("arst_res_valid", 64'(res_valid), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      fill_random(4);
      run_job(4'd4, 2, 2, 1'b0);

      // cfg_passes = 0 treated as one pass
      vals = '{35'h7_FFFF_FFFF};
      run_job(4'd0, 0, 0, 1'b0);

      // 15 passes of the maximum tree value with toggling beat_valid
      vals.delete();
      for (int i = 0; i < 15; i++) vals.push_back(35'h7_FFFF_FFFF);
      run_job(4'd15, 1, 0, 1'b0);

      // Long DONE stall with start and beat_valid pulled high
      fill_random(2);
      run_job(4'd2, 0, 10, 1'b1);

      // Abort on the 2nd of 3 beats
      step();
      start      = 1'b1;
      cfg_passes = 4'd3;
      step();
      start      = 1'b0;
      beat_valid = 1'b1;
      tree_sum   = 35'd11;
      @(negedge clk);
      check("abort_first_beat", 64'(tree_en), 64'd1);
      step();
      abort    = 1'b1;
      tree_sum = 35'd22;
      @(negedge clk);
      check("abort_beat_ready", 64'(beat_ready), 64'd0);
      check("abort_tree_en", 64'(tree_en), 64'd0);
      step();
      abort = 1'b0;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_pass_idx", 64'(pass_idx), 64'd0);
      check("abort_tree_hold", 64'(tree_hold), 64'd0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("abort_res_valid", 64'(res_valid), 64'd0);
         check("idle_beat_ready", 64'(beat_ready), 64'd0);
      end
      step();
      beat_valid = 1'b0;

      // Simultaneous start and abort: abort wins
      start      = 1'b1;
      abort      = 1'b1;
      cfg_passes = 4'd2;
      step();
      start = 1'b0;
      abort = 1'b0;
      check("start_abort_busy", 64'(busy), 64'd0);

      // Abort while a result waits in DONE
      step();
      start      = 1'b1;
      cfg_passes = 4'd1;
      step();
      start      = 1'b0;
      beat_valid = 1'b1;
      tree_sum   = 35'd9;
      step();
      beat_valid = 1'b0;
      check("done_before_abort", 64'(res_valid), 64'd1);
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("done_abort_res_valid", 64'(res_valid), 64'd0);
      check("done_abort_busy", 64'(busy), 64'd0);

      // Randomised jobs
      for (int j = 0; j < 20; j++) begin
         logic [PASS_W-1:0] c;
         c = PASS_W'($urandom_range(0, 15));
         fill_random((c == 0) ? 1 : int'(c));
         run_job(c, 2, int'($urandom_range(0, 3)), 1'($urandom));
      end

      repeat (3) step();
      check("sb_empty", 64'(sb.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/sum_ghi_seq.md
Name: sum_ghi_seq

Overview:
- Sequencer/accumulator controller for the 121-input GHI adder tree (35-bit tree result).
- Paces tile beats into the tree and gates the tree enable.
- Accumulates the per-beat tree sums over a configurable number of passes, e.g. multi-tile or multi-channel windows.
- Returns the final sum to the normalisation stage through a valid/ready handshake.

Parameters:
- TREE_W, 35, width of tree result input and of reg_sum feedback.
- ACC_W, 40, accumulator/result width (TREE_W + PASS_W + 1 headroom).
- PASS_W, 4, width of pass-count config; max passes 2^PASS_W-1 = 15.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse: latch cfg_passes, clear accumulator, begin job; ignored unless IDLE.
- abort  input  1  synchronous job cancel; returns to IDLE next edge.
- cfg_passes  input  PASS_W  beats per job; 0 treated as 1.
- beat_valid  input  1  upstream has 121 GHI products presented to the tree this cycle.
- beat_ready  output  1  controller accepts the beat this cycle.
- tree_en  output  1  drives the tree en; 1 only in the cycle a beat is accepted.
- tree_hold  output  TREE_W  drives the tree reg_sum input = acc[TREE_W-1:0].
- tree_sum  input  TREE_W  tree out_sum (combinational from products).
- res_valid  output  1  final sum available.
- res_ready  input  1  consumer accepts result.
- res_sum  output  ACC_W  final accumulated sum; stable while res_valid.
- busy  output  1  high in ACCUM or DONE.
- pass_idx  output  PASS_W  beats accepted so far in current job.

Behaviour:
- Reset (rst_n=0, async) forces:
  - state=IDLE, acc=0, pass_cnt=0, passes_q=1.
  - beat_ready=0, tree_en=0, res_valid=0, res_sum=0, busy=0.
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - beat_ready=0.
  - On start: passes_q <= (cfg_passes==0 ? 1 : cfg_passes), acc <= 0, pass_cnt <= 0, go to ACCUM.
- ACCUM:
  - beat_ready=1; accept = beat_valid & beat_ready.
  - On accept: tree_en=1 (combinational, same cycle), acc <= acc + zero-extended tree_sum, pass_cnt <= pass_cnt+1.
  - When the accepted beat makes pass_cnt+1 == passes_q: res_sum <= acc + tree_sum, res_valid <= 1, go to DONE. Latency: result visible the cycle after the last beat.
  - No accept: tree_en=0 (tree forwards tree_hold), acc holds. Gaps of any length allowed.
- DONE:
  - beat_ready=0, tree_en=0; res_sum and res_valid held.
  - res_valid & res_ready: res_valid <= 0, go to IDLE.
  - start in the same cycle as the handshake is ignored; start is accepted only once in IDLE.
- abort (priority over everything except reset):
  - In any state: next state IDLE, res_valid <= 0, acc <= 0, pass_cnt <= 0.
  - A beat presented in the same cycle is not accepted (beat_ready forced 0, tree_en=0).
- Simultaneous start and abort: abort wins.
- Arithmetic: unsigned; ACC_W sized so 15 × (2^35-1) never overflows; wraps mod 2^ACC_W only if ACC_W is overridden smaller.
- pass_idx = pass_cnt; wraps to 0 on job start.
- busy = (state != IDLE).
- tree_hold always equals the low TREE_W bits of acc, so the tree output is stable when en=0.

Optional Feature:
- Macro SUM_GHI_SAT_EN.
- Defined: each accumulate saturates at 2^ACC_W-1 instead of wrapping, and a sticky output sat_flag (1 bit) is added.
  - sat_flag reset 0, cleared on start, set when any add in the job saturates, held with res_valid.
- Undefined: modular add, no sat_flag port.

Test Plan:
- Reset mid-ACCUM (after 2 of 4 beats) -> all outputs 0 immediately, state IDLE; next start runs a clean 4-beat job.
- cfg_passes=3, beats with tree_sum 100, 200, 300 back-to-back -> tree_en high 3 cycles; res_valid one cycle after the 3rd beat; res_sum=600; busy drops after res_ready.
- cfg_passes=0, single beat tree_sum=0x7_FFFF_FFFF -> treated as 1 pass; res_sum=0x7_FFFF_FFFF.
- cfg_passes=15, every beat 2^35-1, beat_valid toggling 1/0 -> res_sum=15×(2^35-1)=0x77_FFFF_FFF1; tree_en=0 during gaps; tree_hold tracks acc low bits.
- res_ready held low 10 cycles in DONE, with start pulsed and beat_valid high -> res_sum stable, beat_ready=0, start ignored; res_ready=1 -> IDLE next cycle.
- abort with beat_valid in the cycle of the 2nd of 3 beats -> beat not accepted, IDLE next cycle, res_valid never asserts. With SUM_GHI_SAT_EN and ACC_W=36: two beats of 2^35-1 plus a third beat -> res_sum=2^36-1, sat_flag=1.
